fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream drain stage for the 16x8 sync FIFO. Pops one byte at a time through the FIFO read port (read_en / data_out / empty) and serializes it as an 8N1 UART frame on a single tx line, LSB first. Sits between the FIFO and the chip pad. Consumes the FIFO's registered read data, which is valid the cycle after read_en is sampled.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535; counter width $clog2(CLKS_PER_BIT).
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  high = allowed to start new frames
fifo_empty  input  1  FIFO empty flag
fifo_data_out  input  8  FIFO registered read data
fifo_read_en  output  1  pop request to FIFO; one-cycle pulse
tx  output  1  serial line, idles high
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (reset=0, async): state=IDLE, tx=1, fifo_read_en=0, busy=0, frame_done=0, bit counter=0, baud counter=0, shift register=0. Takes effect immediately, including mid-frame; tx returns high with no partial stop bit.
- States: IDLE, REQ, LOAD, START, DATA, [PARITY], STOP.
- IDLE:
  - if enable=1 and fifo_empty=0, go to REQ; else stay.
  - tx=1.
- REQ: lasts exactly 1 cycle. fifo_read_en=1 (registered Moore output, high only in REQ). Go to LOAD.
- LOAD: lasts 1 cycle. Capture fifo_data_out into an 8-bit shift register. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles. Go to DATA.
- DATA:
  - tx = shreg[0]; each bit is held CLKS_PER_BIT cycles, then shift right.
  - 3-bit bit counter runs 0..7; after bit 7, go to PARITY if compiled in, else STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle.
  - Go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, clears on every state change, never free-runs in IDLE.
- Frame length: (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles, from the first tx=0 cycle to the last stop cycle.
- Back-to-back frames: the inter-frame gap is fixed at 3 cycles of tx=1 (IDLE, REQ, LOAD) beyond the stop bits.
- enable deasserted mid-frame: the current frame completes; no new REQ is issued.
- Exactly one fifo_read_en pulse per frame, and never while fifo_empty=1 in IDLE.
- Empty boundary: fifo_empty rising after the REQ cycle does not abort the frame. Data was already popped.
- tx is driven from a flop; no combinational glitches.

Optional Feature:
UART_PARITY_EN. When defined, adds a PARITY state between DATA and STOP:
- tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
- Frame length grows by CLKS_PER_BIT.

When undefined, the PARITY state and its logic are absent; DATA goes directly to STOP.

Test Plan:
- Reset idle check: reset=0 for 3 cycles, then reset=1, fifo_empty=1, enable=1 for 50 cycles -> tx=1, busy=0, fifo_read_en=0 throughout.
- Single byte, CLKS_PER_BIT=4, STOP_BITS=1, FIFO holding 0xA5:
  - exactly one fifo_read_en pulse;
  - tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total);
  - frame_done pulses once, on cycle 40.
- Back-to-back, FIFO preloaded with 0x00, 0xFF, 0x3C:
  - three frames decoded in order;
  - tx high for exactly 4+3=7 cycles between frames;
  - 3 read pulses; busy drops after the third frame_done.
- Mid-frame async reset: reset=0 during DATA bit 3 of byte 0x5A -> tx=1 and busy=0 in the same cycle; no frame_done. After release, with fifo_empty=1, the block stays IDLE.
- enable gating: 2 bytes queued, enable dropped during the first frame's START -> first frame completes, no second fifo_read_en. Raising enable again -> second frame starts after REQ/LOAD.
- UART_PARITY_EN defined, CLKS_PER_BIT=4:
  - byte 0xA5 -> parity bit 0, 44-cycle frame;
  - byte 0x07 -> parity bit 1.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a registered-output sync FIFO and sends each as a UART frame, LSB first.
// Optional macro UART_PARITY_EN inserts an even-parity bit between the data bits and the stop bit(s).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data_out,
    output logic       fifo_read_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;
`endif

    state_t state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic tx_q, tx_d, rd_en_q, rd_en_d, baud_end;
`ifdef UART_PARITY_EN
    logic par_q, par_d;
`endif

    assign baud_end = baud_q == BAUD_LAST;

    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: state_d = (enable && !fifo_empty) ? REQ : IDLE;
            REQ: state_d = LOAD;
            LOAD: begin
                state_d = START;
                shreg_d = fifo_data_out;
            end
            START: state_d = baud_end ? DATA : START;
            DATA: if (baud_end) begin
                shreg_d = shreg_q >> 1;
                bit_d = bit_q + 3'd1;
`ifdef UART_PARITY_EN
                state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
                state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
            end
`ifdef UART_PARITY_EN
            PARITY: state_d = baud_end ? STOP : PARITY;
`endif
            STOP: if (baud_end) begin
                // bit counter is reused to count stop bits
                state_d = (bit_q == STOP_LAST) ? IDLE : STOP;
                bit_d = (bit_q == STOP_LAST) ? 3'd0 : bit_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
        baud_d = (state_d != state_q || state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
        rd_en_d = state_d == REQ;
`ifdef UART_PARITY_EN
        par_d = (state_q == LOAD) ? ^fifo_data_out : par_q;
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : (state_d == PARITY) ? par_d : 1'b1;
`else
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q <= '0;
            bit_q <= '0;
            shreg_q <= '0;
            tx_q <= 1'b1;
            rd_en_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q <= baud_d;
            bit_q <= bit_d;
            shreg_q <= shreg_d;
            tx_q <= tx_d;
            rd_en_q <= rd_en_d;
`ifdef UART_PARITY_EN
            par_q <= par_d;
`endif
        end
    end

    assign tx = tx_q;
    assign fifo_read_en = rd_en_q;
    assign busy = state_q != IDLE;
    assign frame_done = state_q == STOP && baud_end && bit_q == STOP_LAST;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench; a behavioural FIFO feeds popped bytes into an expected queue,
// and a per-cycle line decoder checks every tx cycle and frame_done against the expected frame.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int SB = 1;
`ifdef UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = (10 + SB - 1 + PAR) * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic fifo_empty = 1'b1;
    logic [7:0] fifo_data_out = 8'h00;
    logic fifo_read_en, tx, busy, frame_done;

    logic [7:0] mem[$];
    logic [7:0] exp_q[$];
    int start_cyc[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frames = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int fpos = 0;
    logic in_frame = 1'b0;
    logic [7:0] cur = 8'h00;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_read_en(fifo_read_en),
        .tx(tx),
        .busy(busy),
        .frame_done(frame_done)
    );

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic load(input logic [7:0] b);
        mem.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (frame_done === 1'b1) done_cnt++;
        if (fifo_read_en === 1'b1) begin
            rd_cnt++;
            checks++;
            if (mem.size() == 0) begin
                failures++;
                $display("FAIL read_on_empty got=1 want=0 cyc=%0d", cyc);
            end else begin
                fifo_data_out = mem.pop_front();
                exp_q.push_back(fifo_data_out);
            end
        end
        fifo_empty = (mem.size() == 0);
        if (!reset) begin
            in_frame = 1'b0;
            exp_q.delete();
        end else begin
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1'b1;
                fpos = 0;
                start_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_frame got=start want=no_start cyc=%0d", cyc);
                    cur = 8'h00;
                end else cur = exp_q.pop_front();
            end
            if (in_frame) begin
                checks++;
                if (tx !== exp_bit(cur, fpos / CPB)) begin
                    failures++;
                    $display("FAIL tx byte=%02h pos=%0d got=%b want=%b", cur, fpos, tx, exp_bit(cur, fpos / CPB));
                end
                checks++;
                if (frame_done !== (fpos == FLEN - 1)) begin
                    failures++;
                    $display("FAIL frame_done byte=%02h pos=%0d got=%b want=%b", cur, fpos, frame_done, fpos == FLEN - 1);
                end
                if (fpos == FLEN - 1) begin
                    in_frame = 1'b0;
                    frames++;
                end
                fpos++;
            end else begin
                checks++;
                if (frame_done !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_done_idle got=%b want=0 cyc=%0d", frame_done, cyc);
                end
            end
        end
    endtask

    task automatic wait_frames(input int n, input int lim);
        int i;
        i = 0;
        while (frames < n && i < lim) begin
            tick();
            i++;
        end
        checks++;
        if (frames < n) begin
            failures++;
            $display("FAIL wait_frames got=%0d want=%0d", frames, n);
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({tx, busy, fifo_read_en} !== 3'b100) begin
                failures++;
                $display("FAIL reset_hold got=%b want=100", {tx, busy, fifo_read_en});
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if ({tx, busy, fifo_read_en} !== 3'b100) begin
                failures++;
                $display("FAIL idle_empty got=%b want=100 cyc=%0d", {tx, busy, fifo_read_en}, cyc);
            end
        end
    endtask

    task automatic test_single();
        int r0, d0;
        r0 = rd_cnt;
        d0 = done_cnt;
        load(8'hA5);
        wait_frames(frames + 1, 200);
        tick();
        checks++;
        if (rd_cnt - r0 != 1) begin
            failures++;
            $display("FAIL single_reads got=%0d want=1", rd_cnt - r0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL single_done got=%0d want=1", done_cnt - d0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int r0, s0;
        r0 = rd_cnt;
        s0 = start_cyc.size();
        load(8'h00);
        load(8'hFF);
        load(8'h3C);
        wait_frames(frames + 3, 600);
        tick();
        checks++;
        if (rd_cnt - r0 != 3) begin
            failures++;
            $display("FAIL b2b_reads got=%0d want=3", rd_cnt - r0);
        end
        checks++;
        if (start_cyc.size() - s0 != 3) begin
            failures++;
            $display("FAIL b2b_starts got=%0d want=3", start_cyc.size() - s0);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (start_cyc[s0+i] - start_cyc[s0+i-1] != FLEN + 3) begin
                    failures++;
                    $display("FAIL b2b_spacing got=%0d want=%0d", start_cyc[s0+i] - start_cyc[s0+i-1], FLEN + 3);
                end
            end
        end
        checks++;
        if ({busy, fifo_read_en, tx} !== 3'b001) begin
            failures++;
            $display("FAIL b2b_end got=%b want=001", {busy, fifo_read_en, tx});
        end
    endtask

    task automatic test_mid_reset();
        int d0;
        load(8'h5A);
        for (int i = 0; i < 200 && !(in_frame && fpos == 4 * CPB + 2); i++) tick();
        checks++;
        if (!(in_frame && fpos == 4 * CPB + 2)) begin
            failures++;
            $display("FAIL mid_reset_reach got=%0d want=%0d", fpos, 4 * CPB + 2);
        end
        d0 = done_cnt;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({tx, busy, frame_done} !== 3'b100) begin
            failures++;
            $display("FAIL mid_reset_async got=%b want=100", {tx, busy, frame_done});
        end
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({tx, busy, fifo_read_en} !== 3'b100) begin
                failures++;
                $display("FAIL post_reset_idle got=%b want=100", {tx, busy, fifo_read_en});
            end
        end
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL mid_reset_done got=%0d want=%0d", done_cnt - d0, 0);
        end
    endtask

    task automatic test_enable();
        int r0, c0;
        r0 = rd_cnt;
        load(8'h11);
        load(8'h22);
        for (int i = 0; i < 20 && !in_frame; i++) tick();
        checks++;
        if (!in_frame) begin
            failures++;
            $display("FAIL enable_start got=idle want=start");
        end
        enable = 1'b0;
        wait_frames(frames + 1, 200);
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if ({busy, fifo_read_en} !== 2'b00) begin
                failures++;
                $display("FAIL enable_gated got=%b want=00", {busy, fifo_read_en});
            end
        end
        checks++;
        if (rd_cnt - r0 != 1) begin
            failures++;
            $display("FAIL enable_reads got=%0d want=1", rd_cnt - r0);
        end
        c0 = cyc;
        enable = 1'b1;
        wait_frames(frames + 1, 200);
        checks++;
        if (start_cyc[$] - c0 != 3) begin
            failures++;
            $display("FAIL enable_resume got=%0d want=3", start_cyc[$] - c0);
        end
        checks++;
        if (rd_cnt - r0 != 2) begin
            failures++;
            $display("FAIL enable_reads2 got=%0d want=2", rd_cnt - r0);
        end
    endtask

    task automatic test_bytes();
        logic [7:0] vals[5];
        vals[0] = 8'hA5;
        vals[1] = 8'h07;
        for (int i = 2; i < 5; i++) vals[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) begin
            load(vals[i]);
            wait_frames(frames + 1, 200);
        end
        tick();
        checks++;
        if (exp_q.size() != 0 || mem.size() != 0) begin
            failures++;
            $display("FAIL leftover got=%0d want=0", exp_q.size() + mem.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mid_reset();
        test_enable();
        test_bytes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
